// File: rtl/cipher_cfg_pkg.sv
// Shared definitions for the cipher configuration loader: chain geometry,
// operation codes, controller states and cipher chain field positions.
package cipher_cfg_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_READ   = 2'b01,
        OP_VERIFY = 2'b10,
        OP_NOP    = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT1 = 2'b01,
        ST_GAP    = 2'b10,
        ST_SHIFT2 = 2'b11
    } state_t;

    // Two LFSRs (taps + state each) plus three single-bit control fields.
    function automatic int chain_len(input int m);
        return 4 * m + 3;
    endfunction

    // Single-bit control fields at the top of the chain.
    function automatic int k_mux_pos(input int m);
        return 4 * m + 2;
    endfunction

    function automatic int a_mux_pos(input int m);
        return 4 * m + 1;
    endfunction

    function automatic int d_en_pos(input int m);
        return 4 * m;
    endfunction

    // LSB positions of the M-bit fields; each field spans [lsb+m-1:lsb].
    function automatic int tx_taps_lsb(input int m);
        return 3 * m;
    endfunction

    function automatic int tx_state_lsb(input int m);
        return 2 * m;
    endfunction

    function automatic int rx_taps_lsb(input int m);
        return m;
    endfunction

    function automatic int rx_state_lsb(input int m);
        return 0;
    endfunction

endpackage

// File: rtl/cipher_cfg_loader_shift_engine.sv
// One contiguous shift pass over the cipher config chain: drives cfg_en and
// cfg_i, captures the outgoing chain into rd_data, flags the last shift.
module cfg_shift_engine #(
    parameter int LEN = 131
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           kick,
    input  logic           recirc,
    input  logic [LEN-1:0] wr_data,
    input  logic           cfg_o,
    output logic           cfg_en,
    output logic           cfg_i,
    output logic [LEN-1:0] rd_data,
    output logic           pass_done
);
    localparam int CW = $clog2(LEN);

    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_nxt;
    logic          en_q;
    logic          recirc_q;
    logic          data_q;

    assign bit_nxt   = bit_cnt + 1'b1;
    assign pass_done = en_q && (bit_cnt == CW'(LEN - 1));
    assign cfg_en    = en_q;
    // Recirculation is combinational so the chain sees its own output bit in the same shift.
    assign cfg_i     = recirc_q ? cfg_o : data_q;

    // Pass sequencing: start on kick, shift LEN cycles without a gap, then go quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= 1'b0;
            recirc_q <= 1'b0;
            data_q   <= 1'b0;
            bit_cnt  <= '0;
            rd_data  <= '0;
        end else if (kick) begin
            en_q     <= 1'b1;
            recirc_q <= recirc;
            data_q   <= recirc ? 1'b0 : wr_data[0];
            bit_cnt  <= '0;
        end else if (en_q) begin
            rd_data <= {cfg_o, rd_data[LEN-1:1]};
            if (pass_done) begin
                en_q     <= 1'b0;
                recirc_q <= 1'b0;
                data_q   <= 1'b0;
                bit_cnt  <= '0;
            end else begin
                data_q  <= wr_data[bit_nxt];
                bit_cnt <= bit_nxt;
            end
        end
    end

endmodule

// File: rtl/cipher_cfg_loader.sv
// Host-side master for the stream cipher config chain: WRITE, READ and
// WRITE-then-READ VERIFY operations, with keystream enables gated while busy.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; done pulse is visible here
// ST_SHIFT1 | first pass (WRITE/VERIFY from image, READ by recirculation)
// ST_GAP    | VERIFY only: GAP idle cycles with cfg_en low
// ST_SHIFT2 | VERIFY only: recirculating read-back pass
module cipher_cfg_loader
    import cipher_cfg_pkg::*;
#(
    parameter int  M         = 32,
    parameter int  GAP       = 2,
    localparam int CHAIN_LEN = chain_len(M)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [CHAIN_LEN-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] rd_data,
    output logic                 mismatch,
    output logic                 cfg_en,
    output logic                 cfg_i,
    input  logic                 cfg_o,
    input  logic                 tx_en_i,
    input  logic                 rx_en_i,
    output logic                 tx_en_o,
    output logic                 rx_en_o
);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t                 state_q;
    state_t                 state_d;
    op_t                    op_q;
    logic [CHAIN_LEN-1:0]   wr_q;
    logic [CHAIN_LEN-1:0]   shift_src;
    logic [GW-1:0]          gap_cnt;
    logic                   accept;
    logic                   kick;
    logic                   recirc;
    logic                   done_d;
    logic                   mm_upd;
    logic                   pass_done;

    assign accept  = (state_q == ST_IDLE) && start && (op != OP_NOP);
    assign tx_en_o = tx_en_i & ~busy;
    assign rx_en_o = rx_en_i & ~busy;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SHIFT1;
            ST_SHIFT1: if (pass_done) state_d = (op_q == OP_VERIFY) ? ST_GAP : ST_IDLE;
            ST_GAP:    if (gap_cnt == '0) state_d = ST_SHIFT2;
            ST_SHIFT2: if (pass_done) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs and engine controls decoded from the current state.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        kick      = 1'b0;
        recirc    = 1'b1;
        done_d    = 1'b0;
        mm_upd    = 1'b0;
        shift_src = wr_q;
        case (state_q)
            ST_IDLE: begin
                kick      = accept;
                recirc    = (op == OP_READ);
                shift_src = wr_data;
                done_d    = start && (op == OP_NOP);
            end
            ST_SHIFT1: done_d = pass_done && (op_q != OP_VERIFY);
            ST_GAP:    kick = (gap_cnt == '0);
            ST_SHIFT2: begin
                done_d = pass_done;
                mm_upd = pass_done;
            end
            default: ;
        endcase
    end

    // Operation latches, gap down-counter, done pulse and VERIFY result.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_NOP;
            wr_q     <= '0;
            gap_cnt  <= '0;
            done     <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= op_t'(op);
                wr_q <= wr_data;
            end
            if ((state_q == ST_SHIFT1) && pass_done)
                gap_cnt <= GW'(GAP - 1);
            else if ((state_q == ST_GAP) && (gap_cnt != '0))
                gap_cnt <= gap_cnt - 1'b1;
            done <= done_d;
            // Compare against the image as it will stand after this final capture.
            if (mm_upd)
                mismatch <= ({cfg_o, rd_data[CHAIN_LEN-1:1]} != wr_q);
        end
    end

    cfg_shift_engine #(
        .LEN (CHAIN_LEN)
    ) u_engine (
        .clk       (clk),
        .rst       (rst),
        .kick      (kick),
        .recirc    (recirc),
        .wr_data   (shift_src),
        .cfg_o     (cfg_o),
        .cfg_en    (cfg_en),
        .cfg_i     (cfg_i),
        .rd_data   (rd_data),
        .pass_done (pass_done)
    );

endmodule

// File: tb/tb_cipher_cfg_loader.sv
// Directed bench for cipher_cfg_loader with a shift-register model of the
// cipher config chain on cfg_i/cfg_o.
module tb_cipher_cfg_loader;
    import cipher_cfg_pkg::*;

    localparam int LEN = 131;
    localparam logic [LEN-1:0] IMG_W =
        {3'b101, 32'hB400_0000, 32'h0000_ACE1, 32'hB400_0000, 32'h0000_1234};
    localparam logic [LEN-1:0] IMG_RST =
        {3'b000, 32'h4800_0000, 32'h0000_0055, 32'h4800_0000, 32'h0000_0055};
    localparam logic [LEN-1:0] IMG_B =
        {3'b010, 32'h1357_9BDF, 32'h0F0F_00FF, 32'hDEAD_BEEF, 32'h8000_0001};

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [1:0]     op = 2'b11;
    logic [LEN-1:0] wr_data = '0;
    logic           busy, done, mismatch, cfg_en, cfg_i, cfg_o;
    logic [LEN-1:0] rd_data;
    logic           tx_en_i = 1'b1;
    logic           rx_en_i = 1'b0;
    logic           tx_en_o, rx_en_o;

    logic           cipher_rst = 1'b0;
    logic           inv_bit7 = 1'b0;
    logic [LEN-1:0] chain = '0;
    int             shift_k = 0;

    int checks = 0;
    int errors = 0;

    cipher_cfg_loader #(.M(32), .GAP(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .rd_data  (rd_data),
        .mismatch (mismatch),
        .cfg_en   (cfg_en),
        .cfg_i    (cfg_i),
        .cfg_o    (cfg_o),
        .tx_en_i  (tx_en_i),
        .rx_en_i  (rx_en_i),
        .tx_en_o  (tx_en_o),
        .rx_en_o  (rx_en_o)
    );

    always #5 clk = ~clk;

    // Cipher chain model: MSB in, LSB out, optional corruption of the 8th bit out.
    assign cfg_o = cfg_en ? (chain[0] ^ (inv_bit7 && (shift_k == 7))) : 1'b0;

    always @(posedge clk) begin
        if (cipher_rst) chain <= IMG_RST;
        else if (cfg_en) chain <= {cfg_i, chain[LEN-1:1]};
        shift_k <= cfg_en ? shift_k + 1 : 0;
    end

    // Issue one operation and watch it for up to 400 cycles.
    task automatic run_op(input logic [1:0] op_v, input logic [LEN-1:0] data,
                          input int start_at, input int rst_at,
                          output int done_at, output int en_cnt, output int en_last,
                          output int rises, output int busy_cnt, output int bad);
        logic prev_en;
        done_at = -1; en_cnt = 0; en_last = -1; rises = 0; busy_cnt = 0; bad = 0;
        prev_en = 1'b0;
        @(negedge clk);
        start = 1'b1; op = op_v; wr_data = data;
        @(negedge clk);
        start = 1'b0; wr_data = ~data;
        for (int n = 1; n <= 400; n++) begin
            if (n > 1) @(negedge clk);
            if (cfg_en) begin
                if (op_v == OP_WRITE || (op_v == OP_VERIFY && n <= LEN)) begin
                    if (cfg_i !== data[en_cnt]) bad++;
                end else if (cfg_i !== cfg_o) bad++;
                en_cnt++;
                en_last = n;
                if (!prev_en) rises++;
            end
            prev_en = cfg_en;
            if (busy) busy_cnt++;
            if (busy && tx_en_o) bad++;
            if (done) begin
                done_at = n;
                break;
            end
            if (n == start_at) begin
                start = 1'b1; op = OP_READ;
            end else start = 1'b0;
            if (n == rst_at) begin
                rst = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cipher_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, mismatch, cfg_en, cfg_i} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, mismatch, cfg_en, cfg_i});
        end
        checks++;
        if (rd_data !== '0) begin
            errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data);
        end
        checks++;
        if (tx_en_o !== 1'b1 || rx_en_o !== 1'b0) begin
            errors++; $display("FAIL reset_en_pass: got tx=%b rx=%b expected tx=1 rx=0", tx_en_o, rx_en_o);
        end
        rst = 1'b0; cipher_rst = 1'b0;
    endtask

    task automatic test_write();
        int d, e, l, r, b, bad;
        run_op(OP_WRITE, IMG_W, 0, 0, d, e, l, r, b, bad);
        checks++;
        if (d !== 132) begin errors++; $display("FAIL write_done_at: got %0d expected 132", d); end
        checks++;
        if (e !== 131 || l !== 131 || r !== 1 || b !== 131) begin
            errors++; $display("FAIL write_en_window: got cnt=%0d last=%0d runs=%0d busy=%0d expected 131 131 1 131", e, l, r, b);
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL write_cfg_i: got %0d bad cycles expected 0", bad); end
        checks++;
        if (rd_data !== IMG_RST) begin errors++; $display("FAIL write_rd_data: got %h expected %h", rd_data, IMG_RST); end
        checks++;
        if (chain !== IMG_W) begin errors++; $display("FAIL write_chain: got %h expected %h", chain, IMG_W); end
    endtask

    task automatic test_read();
        int d, e, l, r, b, bad;
        for (int i = 0; i < 2; i++) begin
            run_op(OP_READ, IMG_B, 0, 0, d, e, l, r, b, bad);
            checks++;
            if (d !== 132 || e !== 131 || bad !== 0) begin
                errors++; $display("FAIL read_timing_%0d: got done=%0d cnt=%0d bad=%0d expected 132 131 0", i, d, e, bad);
            end
            checks++;
            if (rd_data !== IMG_W) begin errors++; $display("FAIL read_rd_data_%0d: got %h expected %h", i, rd_data, IMG_W); end
            checks++;
            if (chain !== IMG_W) begin errors++; $display("FAIL read_chain_%0d: got %h expected %h", i, chain, IMG_W); end
        end
    endtask

    task automatic test_verify();
        int d, e, l, r, b, bad;
        logic [LEN-1:0] exp_bad;
        run_op(OP_VERIFY, IMG_W, 0, 0, d, e, l, r, b, bad);
        checks++;
        if (d !== 265 || e !== 262 || l !== 264 || r !== 2 || bad !== 0) begin
            errors++; $display("FAIL verify_timing: got done=%0d cnt=%0d last=%0d runs=%0d bad=%0d expected 265 262 264 2 0", d, e, l, r, bad);
        end
        checks++;
        if (mismatch !== 1'b0 || rd_data !== IMG_W) begin
            errors++; $display("FAIL verify_ok: got mismatch=%b rd=%h expected 0 %h", mismatch, rd_data, IMG_W);
        end
        exp_bad = IMG_W;
        exp_bad[7] = ~exp_bad[7];
        inv_bit7 = 1'b1;
        run_op(OP_VERIFY, IMG_W, 0, 0, d, e, l, r, b, bad);
        inv_bit7 = 1'b0;
        checks++;
        if (d !== 265 || mismatch !== 1'b1) begin
            errors++; $display("FAIL verify_bad: got done=%0d mismatch=%b expected 265 1", d, mismatch);
        end
        checks++;
        if (rd_data !== exp_bad) begin errors++; $display("FAIL verify_bad_rd: got %h expected %h", rd_data, exp_bad); end
    endtask

    task automatic test_nop_and_ignore();
        int d, e, l, r, b, bad;
        logic [LEN-1:0] exp_rd;
        exp_rd = IMG_W;
        exp_rd[7] = ~exp_rd[7];
        run_op(OP_NOP, IMG_B, 0, 0, d, e, l, r, b, bad);
        checks++;
        if (d !== 1 || e !== 0 || b !== 0) begin
            errors++; $display("FAIL nop_timing: got done=%0d cnt=%0d busy=%0d expected 1 0 0", d, e, b);
        end
        checks++;
        if (rd_data !== exp_rd || mismatch !== 1'b1) begin
            errors++; $display("FAIL nop_hold: got rd=%h mismatch=%b expected %h 1", rd_data, mismatch, exp_rd);
        end
        run_op(OP_WRITE, IMG_B, 40, 0, d, e, l, r, b, bad);
        checks++;
        if (d !== 132 || e !== 131 || r !== 1 || bad !== 0) begin
            errors++; $display("FAIL ignore_timing: got done=%0d cnt=%0d runs=%0d bad=%0d expected 132 131 1 0", d, e, r, bad);
        end
        checks++;
        if (rd_data !== exp_rd || chain !== IMG_B) begin
            errors++; $display("FAIL ignore_data: got rd=%h chain=%h expected %h %h", rd_data, chain, exp_rd, IMG_B);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cfg_en !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL ignore_after: got busy=%b en=%b done=%b expected 0 0 0", busy, cfg_en, done);
        end
    endtask

    task automatic test_rst_mid();
        int d, e, l, r, b, bad;
        int done_seen;
        logic [LEN-1:0] exp_rd;
        exp_rd = {IMG_W[49:0], IMG_B[LEN-1:50]};
        run_op(OP_WRITE, IMG_W, 0, 50, d, e, l, r, b, bad);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (e !== 50 || cfg_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mismatch !== 1'b0 || rd_data !== '0) begin
            errors++; $display("FAIL rst_mid: got cnt=%0d en=%b busy=%b done=%b mm=%b rd=%h expected 50 0 0 0 0 0", e, cfg_en, busy, done, mismatch, rd_data);
        end
        done_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || cfg_en) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL rst_no_done: got %0d active cycles expected 0", done_seen); end
        run_op(OP_WRITE, IMG_W, 0, 0, d, e, l, r, b, bad);
        checks++;
        if (d !== 132 || rd_data !== exp_rd) begin
            errors++; $display("FAIL rst_rewrite: got done=%0d rd=%h expected 132 %h", d, rd_data, exp_rd);
        end
        run_op(OP_READ, IMG_B, 0, 0, d, e, l, r, b, bad);
        checks++;
        if (rd_data !== IMG_W) begin errors++; $display("FAIL rst_reread: got %h expected %h", rd_data, IMG_W); end
    endtask

    task automatic test_back_to_back();
        int d, e, l, r, b, bad;
        int n2;
        run_op(OP_WRITE, IMG_B, 0, 0, d, e, l, r, b, bad);
        start = 1'b1; op = OP_READ;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (d !== 132 || busy !== 1'b1 || cfg_en !== 1'b1) begin
            errors++; $display("FAIL b2b_accept: got done=%0d busy=%b en=%b expected 132 1 1", d, busy, cfg_en);
        end
        n2 = -1;
        for (int n = 1; n <= 400; n++) begin
            if (n > 1) @(negedge clk);
            if (done) begin n2 = n; break; end
        end
        checks++;
        if (n2 !== 132 || rd_data !== IMG_B) begin
            errors++; $display("FAIL b2b_read: got done=%0d rd=%h expected 132 %h", n2, rd_data, IMG_B);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_verify();
        test_nop_and_ignore();
        test_rst_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
